fwrisc_uart_program_loader: RTL

//  Receive side of the UART program-download path. Takes the byte stream from the UART RX

---
 rtl/fwrisc_uart_program_loader.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/fwrisc_uart_program_loader.sv
// UART program loader: packs received bytes little-endian into 32-bit words for FWRISC
// instruction RAM and holds the core in reset until the image is complete.
module fwrisc_uart_program_loader #(
  parameter int unsigned PROG_BYTES = 4096,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned TIMEOUT    = 2000000,
  parameter int unsigned CNT_W      = 13
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_stb_i,
  input  logic              rearm_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              program_receiving_o,
  output logic              program_done_o,
  output logic              program_ov_o,
  output logic              cpu_hold_o,
  output logic [CNT_W-1:0]  byte_count_o
);

  localparam int unsigned TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_FLUSH = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   byte_count_q, byte_count_d;
  logic [31:0]        buf_q, buf_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               recv_q, recv_d;
  logic               done_q, done_d;
  logic               ov_q, ov_d;
  logic               hold_q, hold_d;

  logic [1:0]         lane;
  logic [ADDR_W-1:0]  word_addr;
  logic               last_byte;
  logic               timed_out;

  assign lane      = byte_count_q[1:0];
  assign word_addr = ADDR_W'(byte_count_q >> 2);
  assign last_byte = (byte_count_q == CNT_W'(PROG_BYTES - 1));
  assign timed_out = (TIMEOUT != 0) && (timer_q == TMR_W'(TIMEOUT));

  // Next-state and registered-output logic; rearm overrides everything else.
  always_comb begin
    state_d      = state_q;
    byte_count_d = byte_count_q;
    buf_d        = buf_q;
    timer_d      = timer_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    recv_d       = 1'b0;
    done_d       = done_q;
    ov_d         = ov_q;
    hold_d       = hold_q;

    if (rearm_i) begin
      state_d      = S_LOAD;
      byte_count_d = '0;
      buf_d        = '0;
      timer_d      = '0;
      done_d       = 1'b0;
      ov_d         = 1'b0;
      hold_d       = 1'b1;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (rx_stb_i) begin
            byte_count_d = byte_count_q + CNT_W'(1);
            recv_d       = 1'b1;
            timer_d      = '0;
            buf_d        = buf_q | (32'(rx_data_i) << {lane, 3'b000});
            if (lane == 2'd3) begin
              mem_we_d    = 1'b1;
              mem_addr_d  = word_addr;
              mem_wdata_d = buf_d;
              buf_d       = '0;
            end
            if (last_byte) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              hold_d  = 1'b0;
            end
          end else if (byte_count_q != '0) begin
            if (timed_out) begin
              timer_d = '0;
              if (lane != 2'd0) begin
                state_d = S_FLUSH;
              end else begin
                state_d = S_DONE;
                done_d  = 1'b1;
                hold_d  = 1'b0;
              end
            end else if (TIMEOUT != 0) begin
              timer_d = timer_q + TMR_W'(1);
            end
          end
        end
        S_FLUSH: begin
          // Unfilled lanes of the buffer are already zero.
          mem_we_d    = 1'b1;
          mem_addr_d  = word_addr;
          mem_wdata_d = buf_q;
          buf_d       = '0;
          state_d     = S_DONE;
          done_d      = 1'b1;
          hold_d      = 1'b0;
          if (rx_stb_i) ov_d = 1'b1;
        end
        S_DONE: begin
          if (rx_stb_i) ov_d = 1'b1;
        end
        default: begin
          state_d = S_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_LOAD;
      byte_count_q <= '0;
      buf_q        <= '0;
      timer_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      recv_q       <= 1'b0;
      done_q       <= 1'b0;
      ov_q         <= 1'b0;
      hold_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      byte_count_q <= byte_count_d;
      buf_q        <= buf_d;
      timer_q      <= timer_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      recv_q       <= recv_d;
      done_q       <= done_d;
      ov_q         <= ov_d;
      hold_q       <= hold_d;
    end
  end

  assign mem_we_o            = mem_we_q;
  assign mem_addr_o          = mem_addr_q;
  assign mem_wdata_o         = mem_wdata_q;
  assign program_receiving_o = recv_q;
  assign program_done_o      = done_q;
  assign program_ov_o        = ov_q;
  assign cpu_hold_o          = hold_q;
  assign byte_count_o        = byte_count_q;

endmodule
